// File: rtl/galaksija_sysctl.sv
// galaksija_sysctl: fractional CPU clock enable, frame interrupt with ack/timeout/overrun, and control latch.
module galaksija_sysctl #(
  parameter int f_clk       = 25000000,
  parameter int f_cpu       = 3072000,
  parameter int turbo_mult  = 2,
  parameter int acc_bits    = 20,
  parameter int f_int       = 50,
  parameter int int_hold    = 64,
  parameter int latch_width = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   turbo,
  input  logic                   cpu_pause,
  output logic                   cen,
  output logic                   int_n,
  input  logic                   int_ack,
  output logic [7:0]             overrun_cnt,
  output logic [15:0]            frame_cnt,
  input  logic                   wr_latch,
  input  logic [latch_width-1:0] latch_d,
  output logic [latch_width-1:0] latch_q
);
  localparam logic [63:0] inc_n64 = (64'(f_cpu) << acc_bits) / 64'(f_clk);
  localparam logic [63:0] inc_t64 = ((64'(f_cpu) * 64'(turbo_mult)) << acc_bits) / 64'(f_clk);
  localparam logic [acc_bits-1:0] inc_n = inc_n64[acc_bits-1:0];
  localparam logic [acc_bits-1:0] inc_t = inc_t64[acc_bits-1:0];
  localparam int period = f_clk / f_int;
  localparam int pre_w = period > 1 ? $clog2(period) : 1;
  localparam int hold_w = $clog2(int_hold + 1);

  typedef enum logic {idle, pend} state_t;

  logic [acc_bits:0] acc;
  logic [pre_w-1:0]  pre;
  logic [hold_w-1:0] hold_cnt, hold_nx;
  state_t            state, state_nx;
  logic              tick, timeout, overrun;

  assign cen   = acc[acc_bits];
  assign int_n = state != pend;

  // The carry bit is dropped every cycle, so each overflow shows on cen exactly once.
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else acc <= cpu_pause ? {1'b0, acc[acc_bits-1:0]}
                          : {1'b0, acc[acc_bits-1:0]} + {1'b0, turbo ? inc_t : inc_n};

  always_comb begin
    tick     = pre == pre_w'(period - 1);
    timeout  = state == pend && hold_cnt == hold_w'(int_hold);
    overrun  = tick && state == pend && !int_ack && !timeout;
    state_nx = tick ? pend : (state == pend && (int_ack || timeout)) ? idle : state;
    hold_nx  = tick ? '0 : (state == pend && cen) ? hold_cnt + hold_w'(1) : hold_cnt;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= idle;
      hold_cnt    <= '0;
      pre         <= '0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      latch_q     <= '0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      pre         <= tick ? '0 : pre + pre_w'(1);
      frame_cnt   <= frame_cnt + 16'(tick);
      overrun_cnt <= (overrun && overrun_cnt != 8'hff) ? overrun_cnt + 8'd1 : overrun_cnt;
      latch_q     <= wr_latch ? latch_d : latch_q;
    end
endmodule
